// File: rtl/rr_alu_arbiter_if.sv
// Bundle between the requesting pipeline units and the round-robin arbiter
// that owns the shared 4:1 result mux select.
// Handshake: a requester holds req[i] high for as long as it wants the path.
// grant[i] (registered) tells it that it owns the path. The owner pulses done
// for the cycle its transaction completes. done is ignored while busy is low.
interface rr_alu_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] control;
  logic       busy;
  logic       timeout;
  logic       dbgState;   // 0 = IDLE, 1 = GRANT

  // Requester side.
  modport master (
    output req, done,
    input  grant, control, busy, timeout, dbgState
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output grant, control, busy, timeout, dbgState
  );
endinterface

// File: rtl/rr_alu_arbiter.sv
// Round-robin arbiter for one shared 4-input result path. It issues a
// registered one-hot grant, holds it until done, until the owner drops its
// request, or until the hold limit forces a release. On release, the search
// for the next owner starts just after the previous owner.
module rr_alu_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  rr_alu_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           stateQ, stateD;
  logic [1:0]       ptrQ, ptrD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [3:0]       grantQ, grantD;
  logic [1:0]       controlQ, controlD;
  logic             busyQ, busyD;
  logic             timeoutQ, timeoutD;

  // Returns {found, index} of the first requester at or after base, wrapping.
  function automatic logic [2:0] pickWinner(input logic [3:0] reqVec,
                                            input logic [1:0] base);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (reqVec[idx]) result = {1'b1, idx};
    end
    return result;
  endfunction

  logic [1:0] curIdx;
  logic       relDone, relDrop, relHold, release_;
  logic [1:0] nextPtr;
  logic [2:0] idleWin, relWin;

  // Release causes for the current owner; control always holds its index.
  always_comb begin
    curIdx   = controlQ;
    relDone  = bus.done;
    relDrop  = ~bus.req[curIdx];
    relHold  = (cntQ == HOLD_LAST);
    release_ = relDone | relDrop | relHold;
    nextPtr  = curIdx + 2'd1;
    idleWin  = pickWinner(bus.req, ptrQ);
    relWin   = pickWinner(bus.req, nextPtr);
  end

  // Next-state and registered-output logic.
  always_comb begin
    stateD   = stateQ;
    ptrD     = ptrQ;
    cntD     = cntQ;
    grantD   = grantQ;
    controlD = controlQ;
    busyD    = busyQ;
    timeoutD = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (idleWin[2]) begin
          stateD   = GRANT;
          grantD   = 4'b0001 << idleWin[1:0];
          controlD = idleWin[1:0];
          busyD    = 1'b1;
          cntD     = '0;
        end
      end
      GRANT: begin
        if (release_) begin
          ptrD     = nextPtr;
          // A forced release is flagged only when nothing else ended the grant.
          timeoutD = relHold & ~relDone & ~relDrop;
          if (relWin[2]) begin
            grantD   = 4'b0001 << relWin[1:0];
            controlD = relWin[1:0];
            cntD     = '0;
          end else begin
            stateD = IDLE;
            grantD = 4'b0000;
            busyD  = 1'b0;
            cntD   = '0;
          end
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= IDLE;
      ptrQ     <= 2'd0;
      cntQ     <= '0;
      grantQ   <= 4'b0000;
      controlQ <= 2'd0;
      busyQ    <= 1'b0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      ptrQ     <= ptrD;
      cntQ     <= cntD;
      grantQ   <= grantD;
      controlQ <= controlD;
      busyQ    <= busyD;
      timeoutQ <= timeoutD;
    end
  end

  assign bus.grant    = grantQ;
  assign bus.control  = controlQ;
  assign bus.busy     = busyQ;
  assign bus.timeout  = timeoutQ;
  assign bus.dbgState = stateQ;

endmodule

// File: tb/tb_rr_alu_arbiter.sv
// Bench for rr_alu_arbiter: directed scenarios followed by random traffic.
// The driver predicts each edge's outputs with a cycle-count reference model
// and queues them. The monitor compares at the falling edge.
module tb_rr_alu_arbiter;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;
  rr_alu_arbiter_if bus ();

  rr_alu_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Reference model: owner index, how many cycles the grant has been visible,
  // and the rotating start point.
  logic [7:0] exp_q[$];
  bit  mBusy;
  int  mOwner;
  int  mHeld;
  int  mPtr;
  int  mControl;
  bit  mTimeout;

  function automatic int scanFrom(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic modelEdge(input logic [3:0] r, input logic d, input logic rs);
    int w;
    bit ownerStillWants;
    mTimeout = 1'b0;
    if (rs) begin
      mBusy = 0; mOwner = 0; mHeld = 0; mPtr = 0; mControl = 0;
    end else if (!mBusy) begin
      w = scanFrom(r, mPtr);
      if (w >= 0) begin
        mBusy = 1; mOwner = w; mControl = w; mHeld = 1;
      end
    end else begin
      ownerStillWants = r[mOwner];
      if (d || !ownerStillWants || mHeld == MAX_HOLD) begin
        mTimeout = (mHeld == MAX_HOLD) && !d && ownerStillWants;
        mPtr = (mOwner + 1) % 4;
        w = scanFrom(r, mPtr);
        if (w >= 0) begin
          mOwner = w; mControl = w; mHeld = 1;
        end else begin
          mBusy = 0; mHeld = 0;
        end
      end else begin
        mHeld++;
      end
    end
  endtask

  function automatic logic [7:0] modelOut();
    logic [3:0] g;
    g = mBusy ? (4'b0001 << mOwner) : 4'b0000;
    return {g, 2'(mControl), mBusy, mTimeout};
  endfunction

  // Driver: apply inputs for one edge, then queue the predicted result.
  task automatic applyCycle(input logic [3:0] r, input logic d, input logic rs);
    bus.req  = r;
    bus.done = d;
    rst      = rs;
    @(posedge clk);
    #1;
    modelEdge(r, d, rs);
    exp_q.push_back(modelOut());
  endtask

  // Monitor: compare every presented output against the queued prediction.
  initial begin
    logic [7:0] got;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {bus.grant, bus.control, bus.busy, bus.timeout};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL outputs t=%0t grant/control/busy/timeout got=%b_%b_%b_%b want=%b_%b_%b_%b",
                   $time, got[7:4], got[3:2], got[1], got[0],
                   exp[7:4], exp[3:2], exp[1], exp[0]);
        end
        checks++;
        if (bus.busy !== (|bus.grant) || $countones(bus.grant) > 1) begin
          failures++;
          $display("FAIL onehot_busy t=%0t grant=%b busy=%b", $time, bus.grant, bus.busy);
        end
        checks++;
        if (bus.dbgState !== bus.busy) begin
          failures++;
          $display("FAIL state_busy t=%0t state=%b busy=%b", $time, bus.dbgState, bus.busy);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    rst      = 1'b1;

    // Single request then done with requests withdrawn.
    applyCycle(4'b0000, 1'b0, 1'b1);
    applyCycle(4'b0000, 1'b0, 1'b1);
    applyCycle(4'b0001, 1'b0, 1'b0);
    applyCycle(4'b0000, 1'b1, 1'b0);
    applyCycle(4'b0000, 1'b0, 1'b0);
    // Done while idle is ignored.
    applyCycle(4'b0000, 1'b1, 1'b0);

    // Fair rotation with everyone requesting.
    applyCycle(4'b0000, 1'b0, 1'b1);
    applyCycle(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyCycle(4'b1111, 1'b1, 1'b0);

    // Back-to-back wrap from index 3 to index 0.
    applyCycle(4'b0000, 1'b0, 1'b1);
    applyCycle(4'b1000, 1'b0, 1'b0);
    applyCycle(4'b1001, 1'b1, 1'b0);
    applyCycle(4'b1001, 1'b0, 1'b0);

    // Hold timeout, then a lone requester re-granted on timeout.
    applyCycle(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyCycle(4'b0110, 1'b0, 1'b0);
    applyCycle(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyCycle(4'b0010, 1'b0, 1'b0);

    // Owner drops its request on the last allowed cycle: no timeout pulse.
    applyCycle(4'b0000, 1'b0, 1'b1);
    applyCycle(4'b0101, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyCycle(4'b0101, 1'b0, 1'b0);
    applyCycle(4'b0100, 1'b0, 1'b0);
    // Done coinciding with the hold limit also gives no timeout pulse.
    for (int i = 0; i < 3; i++) applyCycle(4'b0101, 1'b0, 1'b0);
    applyCycle(4'b0101, 1'b1, 1'b0);
    applyCycle(4'b0000, 1'b0, 1'b0);

    // Reset in the middle of a grant, then everyone requests.
    applyCycle(4'b0000, 1'b0, 1'b1);
    applyCycle(4'b0100, 1'b0, 1'b0);
    applyCycle(4'b0100, 1'b0, 1'b0);
    applyCycle(4'b0100, 1'b0, 1'b0);
    applyCycle(4'b1111, 1'b0, 1'b1);
    applyCycle(4'b1111, 1'b0, 1'b0);
    applyCycle(4'b1111, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      logic d;
      logic rs;
      r  = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 79) == 0);
      applyCycle(r, d, rs);
    end

    applyCycle(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain queue_left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
